// File: rtl/bp_fpga_host_io_in.sv
// Host-to-BlackParrot link input: UART RX bytes are assembled into NBF packets, issued as IO
// commands, and answered with NBF packets. IO message layout: {data[63:0], addr, size[2:0], msg_type[3:0]}.
module bp_fpga_host_io_in
  #(parameter int paddr_width_p      = 40
   ,parameter int nbf_addr_width_p   = paddr_width_p
   ,parameter int nbf_data_width_p   = 64
   ,parameter int uart_clk_per_bit_p = 10416
   ,parameter int uart_data_bits_p   = 8
   ,parameter int uart_parity_bit_p  = 0
   ,parameter int uart_stop_bits_p   = 1
   ,parameter int uart_parity_odd_p  = 0
   ,parameter int rx_fifo_els_p      = 16
   ,parameter int max_credits_p      = 16
   ,localparam int io_data_width_lp    = 64
   ,localparam int io_mem_msg_width_lp = io_data_width_lp + paddr_width_p + 7
   ,localparam int nbf_width_lp        = 8 + nbf_addr_width_p + nbf_data_width_p
   )
   (input  logic                           clk_i
   ,input  logic                           reset_n_i
   ,input  logic                           rx_i
   ,output logic [io_mem_msg_width_lp-1:0] io_cmd_o
   ,output logic                           io_cmd_v_o
   ,input  logic                           io_cmd_ready_and_i
   ,input  logic [io_mem_msg_width_lp-1:0] io_resp_i
   ,input  logic                           io_resp_v_i
   ,output logic                           io_resp_yumi_o
   ,output logic [nbf_width_lp-1:0]        nbf_o
   ,output logic                           nbf_v_o
   ,input  logic                           nbf_ready_and_i
   );

    localparam logic [7:0] op_write_8 = 8'h03, op_read_8 = 8'h13, op_fence = 8'hFE;
    localparam logic [7:0] op_finish = 8'hFF, op_error = 8'hEE;
    localparam logic [3:0] msg_uc_rd = 4'd2, msg_uc_wr = 4'd3;
    localparam logic [2:0] msg_size_8 = 3'd3;
    localparam int nbf_bytes_lp = nbf_width_lp / 8;
    localparam int byte_cnt_w_lp = $clog2(nbf_bytes_lp);
    localparam int clk_cnt_w_lp = $clog2(uart_clk_per_bit_p);
    localparam int fifo_ptr_w_lp = $clog2(rx_fifo_els_p);
    localparam int credit_w_lp = $clog2(max_credits_p + 1);
    localparam logic [credit_w_lp-1:0] max_credits_lp = credit_w_lp'(max_credits_p);
    localparam logic [fifo_ptr_w_lp-1:0] fifo_last_lp = fifo_ptr_w_lp'(rx_fifo_els_p - 1);
    localparam logic [fifo_ptr_w_lp:0] fifo_els_lp = (fifo_ptr_w_lp+1)'(rx_fifo_els_p);

    // ---------------- UART receiver ----------------
    typedef enum logic [2:0] {e_rx_idle, e_rx_start, e_rx_data, e_rx_parity, e_rx_stop} rx_state_e;
    rx_state_e                 rx_state_reg;
    logic [2:0]                rx_sync_reg;
    logic [clk_cnt_w_lp-1:0]   clk_cnt_reg;
    logic [2:0]                bit_cnt_reg;
    logic [1:0]                stop_cnt_reg;
    logic [7:0]                rx_shift_reg;
    logic                      rx_bad_reg, rx_v_reg, rx_err_reg;
    logic                      rx_s, rx_prev, bit_tick;

    assign rx_s     = rx_sync_reg[1];
    assign rx_prev  = rx_sync_reg[2];
    assign bit_tick = (clk_cnt_reg == clk_cnt_w_lp'(uart_clk_per_bit_p - 1));

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rx_sync_reg  <= '1;
            rx_state_reg <= e_rx_idle;
            clk_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= '0;
            rx_shift_reg <= '0;
            rx_bad_reg   <= 1'b0;
            rx_v_reg     <= 1'b0;
            rx_err_reg   <= 1'b0;
        end else begin
            rx_sync_reg <= {rx_sync_reg[1:0], rx_i};
            rx_v_reg    <= 1'b0;
            clk_cnt_reg <= bit_tick ? '0 : clk_cnt_reg + 1'b1;
            case (rx_state_reg)
                e_rx_idle: begin
                    // Preloading half a bit period makes every later tick land mid-bit
                    clk_cnt_reg <= clk_cnt_w_lp'(uart_clk_per_bit_p / 2);
                    rx_bad_reg  <= 1'b0;
                    if (rx_prev && !rx_s)
                        rx_state_reg <= e_rx_start;
                end
                e_rx_start: if (bit_tick) begin
                    bit_cnt_reg  <= '0;
                    rx_state_reg <= rx_s ? e_rx_idle : e_rx_data;
                end
                e_rx_data: if (bit_tick) begin
                    rx_shift_reg <= {rx_s, rx_shift_reg[7:1]};
                    bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                    stop_cnt_reg <= '0;
                    if (bit_cnt_reg == 3'(uart_data_bits_p - 1))
                        rx_state_reg <= (uart_parity_bit_p != 0) ? e_rx_parity : e_rx_stop;
                end
                e_rx_parity: if (bit_tick) begin
                    if ((^rx_shift_reg ^ rx_s) != (uart_parity_odd_p != 0))
                        rx_bad_reg <= 1'b1;
                    rx_state_reg <= e_rx_stop;
                end
                e_rx_stop: if (bit_tick) begin
                    stop_cnt_reg <= stop_cnt_reg + 1'b1;
                    if (!rx_s)
                        rx_bad_reg <= 1'b1;
                    if (stop_cnt_reg == 2'(uart_stop_bits_p - 1)) begin
                        rx_v_reg     <= 1'b1;
                        rx_err_reg   <= rx_bad_reg | !rx_s;
                        rx_state_reg <= e_rx_idle;
                    end
                end
                default: rx_state_reg <= e_rx_idle;
            endcase
        end
    end

    // ---------------- received-byte FIFO ----------------
    logic [7:0]               fifo_mem [rx_fifo_els_p];
    logic [fifo_ptr_w_lp-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [fifo_ptr_w_lp:0]   fifo_cnt_reg;
    logic                     fifo_full, fifo_empty, fifo_push, fifo_pop;

    assign fifo_full  = (fifo_cnt_reg == fifo_els_lp);
    assign fifo_empty = (fifo_cnt_reg == '0);
    assign fifo_push  = rx_v_reg && !rx_err_reg && !fifo_full;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
        end else begin
            if (fifo_push)
                wr_ptr_reg <= (wr_ptr_reg == fifo_last_lp) ? '0 : wr_ptr_reg + 1'b1;
            if (fifo_pop)
                rd_ptr_reg <= (rd_ptr_reg == fifo_last_lp) ? '0 : rd_ptr_reg + 1'b1;
            if (fifo_push && !fifo_pop)
                fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
            else if (!fifo_push && fifo_pop)
                fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fifo_push)
            fifo_mem[wr_ptr_reg] <= rx_shift_reg;
    end

    // ---------------- packet FSM ----------------
    typedef enum logic [2:0] {e_reset, e_ready, e_send_cmd, e_wait_read, e_fence, e_send_nbf} state_e;
    state_e                      state_reg;
    logic [nbf_width_lp-1:0]     pkt_reg, nbf_reg;
    logic [byte_cnt_w_lp-1:0]    byte_cnt_reg;
    logic                        pkt_done_reg, framing_err_reg, overrun_err_reg;
    logic [credit_w_lp-1:0]      credit_reg;
    logic [7:0]                  pkt_op;
    logic [nbf_addr_width_p-1:0] pkt_addr;
    logic [nbf_data_width_p-1:0] pkt_data;
    logic [io_data_width_lp-1:0] resp_data;
    logic                        is_write, err_pending, wr_resp, rd_resp, cmd_wr_hs, credit_dec;
    logic                        framing_set, overrun_set, unused_resp_bits;

    assign pkt_op      = pkt_reg[7:0];
    assign pkt_addr    = pkt_reg[8 +: nbf_addr_width_p];
    assign pkt_data    = pkt_reg[8 + nbf_addr_width_p +: nbf_data_width_p];
    assign is_write    = (pkt_op == op_write_8);
    assign err_pending = framing_err_reg || overrun_err_reg;
    assign framing_set = rx_v_reg && rx_err_reg;
    assign overrun_set = rx_v_reg && !rx_err_reg && fifo_full;
    assign fifo_pop    = (state_reg == e_ready) && !pkt_done_reg && !fifo_empty
                         && !((byte_cnt_reg == '0) && err_pending);

    assign resp_data        = io_resp_i[io_mem_msg_width_lp-1 -: io_data_width_lp];
    assign unused_resp_bits = ^io_resp_i[io_mem_msg_width_lp-io_data_width_lp-1:4];
    // Write acks are drained in every state so credits keep flowing; read data only when awaited
    assign wr_resp = io_resp_v_i && (io_resp_i[3:0] == msg_uc_wr) && (state_reg != e_reset);
    assign rd_resp = io_resp_v_i && (io_resp_i[3:0] == msg_uc_rd) && (state_reg == e_wait_read);
    assign io_resp_yumi_o = wr_resp || rd_resp;

    assign io_cmd_v_o = (state_reg == e_send_cmd) && (!is_write || (credit_reg < max_credits_lp));
    assign io_cmd_o   = {io_data_width_lp'(pkt_data), paddr_width_p'(pkt_addr), msg_size_8,
                         is_write ? msg_uc_wr : msg_uc_rd};
    assign cmd_wr_hs  = io_cmd_v_o && io_cmd_ready_and_i && is_write;
    assign credit_dec = wr_resp && (credit_reg != '0);
    assign nbf_v_o    = (state_reg == e_send_nbf);
    assign nbf_o      = nbf_reg;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_reg       <= e_reset;
            pkt_reg         <= '0;
            nbf_reg         <= '0;
            byte_cnt_reg    <= '0;
            pkt_done_reg    <= 1'b0;
            credit_reg      <= '0;
            framing_err_reg <= 1'b0;
            overrun_err_reg <= 1'b0;
        end else begin
            framing_err_reg <= framing_err_reg | framing_set;
            overrun_err_reg <= overrun_err_reg | overrun_set;
            if (cmd_wr_hs && !credit_dec)
                credit_reg <= credit_reg + 1'b1;
            else if (!cmd_wr_hs && credit_dec)
                credit_reg <= credit_reg - 1'b1;

            case (state_reg)
                e_reset: state_reg <= e_ready;
                e_ready: begin
                    if (pkt_done_reg) begin
                        pkt_done_reg <= 1'b0;
                        case (pkt_op)
                            op_write_8, op_read_8: state_reg <= e_send_cmd;
                            op_fence:              state_reg <= e_fence;
                            op_finish: begin
                                nbf_reg   <= pkt_reg;
                                state_reg <= e_send_nbf;
                            end
                            default: begin
                                nbf_reg   <= {nbf_data_width_p'(pkt_op), {nbf_addr_width_p{1'b0}}, op_error};
                                state_reg <= e_send_nbf;
                            end
                        endcase
                    end else if ((byte_cnt_reg == '0) && err_pending) begin
                        nbf_reg <= {nbf_data_width_p'({overrun_err_reg, framing_err_reg}),
                                    {nbf_addr_width_p{1'b0}}, op_error};
                        framing_err_reg <= framing_set;
                        overrun_err_reg <= overrun_set;
                        state_reg       <= e_send_nbf;
                    end else if (fifo_pop) begin
                        pkt_reg[8*byte_cnt_reg +: 8] <= fifo_mem[rd_ptr_reg];
                        if (byte_cnt_reg == byte_cnt_w_lp'(nbf_bytes_lp - 1)) begin
                            byte_cnt_reg <= '0;
                            pkt_done_reg <= 1'b1;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 1'b1;
                        end
                    end
                end
                e_send_cmd: if (io_cmd_v_o && io_cmd_ready_and_i)
                    state_reg <= is_write ? e_ready : e_wait_read;
                e_wait_read: if (rd_resp) begin
                    nbf_reg   <= {nbf_data_width_p'(resp_data), pkt_addr, op_read_8};
                    state_reg <= e_send_nbf;
                end
                e_fence: if (credit_reg == '0) begin
                    nbf_reg   <= {{nbf_data_width_p{1'b0}}, {nbf_addr_width_p{1'b0}}, op_fence};
                    state_reg <= e_send_nbf;
                end
                e_send_nbf: if (nbf_ready_and_i)
                    state_reg <= e_ready;
                default: state_reg <= e_reset;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_fpga_host_io_in.sv
`timescale 1ns/1ps
module tb_bp_fpga_host_io_in;
    localparam int PADDR = 40;
    localparam int CPB   = 8;
    localparam int MAXC  = 2;
    localparam int MSGW  = 64 + PADDR + 7;
    localparam int NBFW  = 8 + PADDR + 64;

    logic            clk = 1'b0;
    logic            reset_n_i;
    logic            rx_i;
    logic [MSGW-1:0] io_cmd_o;
    logic            io_cmd_v_o;
    logic            io_cmd_ready_and_i;
    logic [MSGW-1:0] io_resp_i;
    logic            io_resp_v_i;
    logic            io_resp_yumi_o;
    logic [NBFW-1:0] nbf_o;
    logic            nbf_v_o;
    logic            nbf_ready_and_i;

    always #5 clk = ~clk;

    bp_fpga_host_io_in #(
        .paddr_width_p(PADDR), .uart_clk_per_bit_p(CPB), .max_credits_p(MAXC)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .rx_i(rx_i),
        .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_and_i(io_cmd_ready_and_i),
        .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_yumi_o(io_resp_yumi_o),
        .nbf_o(nbf_o), .nbf_v_o(nbf_v_o), .nbf_ready_and_i(nbf_ready_and_i)
    );

    int n_cmp = 0;
    int n_mis = 0;

    logic [MSGW-1:0]  cmd_q[$];
    logic [NBFW-1:0]  nbf_q[$];
    int               nbf_acks_q[$];
    int               wr_due_q[$];
    int               cycle = 0;
    int               wr_acks = 0;
    int               resp_delay = 20;
    int               release_cycle = 0;
    bit               hold_wr = 0;
    bit               rd_pending = 0;
    bit               resp_taken = 0;
    logic [63:0]      rd_data = 64'h0;
    logic [PADDR-1:0] rd_addr = '0;

    function automatic logic [MSGW-1:0] exp_cmd(logic [7:0] op, logic [39:0] a, logic [63:0] d);
        return {d, a, 3'd3, (op == 8'h03) ? 4'd3 : 4'd2};
    endfunction

    function automatic logic [NBFW-1:0] exp_nbf(logic [7:0] op, logic [39:0] a, logic [63:0] d);
        if (op == 8'hFF) return {d, a, op};
        if (op == 8'hFE) return {64'h0, 40'h0, 8'hFE};
        return {{56'h0, op}, 40'h0, 8'hEE};
    endfunction

    function automatic logic [NBFW-1:0] err_nbf(logic [63:0] d);
        return {d, 40'h0, 8'hEE};
    endfunction

    initial begin
        io_cmd_ready_and_i = 1'b1;
        io_resp_v_i = 1'b0;
        io_resp_i = '0;
        forever begin
            @(negedge clk);
            if (resp_taken) begin
                io_resp_v_i = 1'b0;
                resp_taken = 1'b0;
            end
            if (!io_resp_v_i) begin
                if (rd_pending) begin
                    io_resp_i = {rd_data, rd_addr, 3'd3, 4'd2};
                    io_resp_v_i = 1'b1;
                    rd_pending = 1'b0;
                end else if (wr_due_q.size() > 0 && !hold_wr && cycle >= wr_due_q[0]
                             && cycle >= release_cycle) begin
                    io_resp_i = {64'h0, {PADDR{1'b0}}, 3'd3, 4'd3};
                    io_resp_v_i = 1'b1;
                    void'(wr_due_q.pop_front());
                end
            end
            #1;
            if (io_cmd_v_o && io_cmd_ready_and_i) begin
                cmd_q.push_back(io_cmd_o);
                if (io_cmd_o[3:0] == 4'd3) wr_due_q.push_back(cycle + resp_delay);
                else begin
                    rd_pending = 1'b1;
                    rd_addr = io_cmd_o[7 +: PADDR];
                end
            end
            if (io_resp_v_i && io_resp_yumi_o) begin
                resp_taken = 1'b1;
                if (io_resp_i[3:0] == 4'd3) wr_acks++;
            end
            if (nbf_v_o && nbf_ready_and_i) begin
                nbf_q.push_back(nbf_o);
                nbf_acks_q.push_back(wr_acks);
            end
            cycle++;
        end
    end

    task automatic send_bits(input logic [7:0] b, input logic stop);
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_i = stop;
        repeat (CPB) @(negedge clk);
        rx_i = 1'b1;
    endtask

    task automatic send_pkt(input logic [7:0] op, input logic [39:0] a, input logic [63:0] d);
        logic [111:0] p;
        p = {d, a, op};
        $display("tx packet op=%02h addr=%010h data=%016h", op, a, d);
        for (int i = 0; i < 14; i++) send_bits(p[8*i +: 8], 1'b1);
    endtask

    task automatic wait_q(input int ncmd, input int nnbf, input int budget);
        int t;
        t = 0;
        while ((cmd_q.size() < ncmd || nbf_q.size() < nnbf) && t < budget) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic clear_q();
        cmd_q.delete();
        nbf_q.delete();
        nbf_acks_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] a;
        logic [63:0] d;
        logic [7:0]  op;
        logic [39:0] wa [3];
        logic [63:0] wd [3];
        logic [7:0]  ops [4];
        int          base_acks;
        int          exp_stall;

        reset_n_i = 1'b0;
        rx_i = 1'b1;
        nbf_ready_and_i = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        n_cmp++;
        if (io_cmd_v_o !== 1'b0) begin n_mis++; $display("FAIL reset_cmd_v: observed %0h", io_cmd_v_o); end
        n_cmp++;
        if (nbf_v_o !== 1'b0) begin n_mis++; $display("FAIL reset_nbf_v: observed %0h", nbf_v_o); end
        n_cmp++;
        if (io_resp_yumi_o !== 1'b0) begin n_mis++; $display("FAIL reset_yumi: observed %0h", io_resp_yumi_o); end
        @(negedge clk);
        reset_n_i = 1'b1;
        repeat (10) @(negedge clk);

        clear_q();
        a = 40'h00_8000_0000;
        d = 64'h1122334455667788;
        send_pkt(8'h03, a, d);
        wait_q(1, 0, 400);
        repeat (60) @(negedge clk);
        n_cmp++;
        if (cmd_q.size() !== 1) begin n_mis++; $display("FAIL wr_cmd_count: observed %0d", cmd_q.size()); end
        if (cmd_q.size() > 0) begin
            n_cmp++;
            if (cmd_q[0] !== exp_cmd(8'h03, a, d)) begin n_mis++; $display("FAIL wr_cmd: observed %0h required %0h", cmd_q[0], exp_cmd(8'h03, a, d)); end
        end
        n_cmp++;
        if (wr_acks !== 1) begin n_mis++; $display("FAIL wr_ack_count: observed %0d", wr_acks); end
        n_cmp++;
        if (nbf_q.size() !== 0) begin n_mis++; $display("FAIL wr_no_nbf: observed %0d", nbf_q.size()); end

        clear_q();
        base_acks = wr_acks;
        hold_wr = 1'b1;
        resp_delay = 200;
        for (int i = 0; i < 3; i++) begin
            wa[i] = {8'h00, 32'($urandom())};
            wd[i] = {32'($urandom()), 32'($urandom())};
            send_pkt(8'h03, wa[i], wd[i]);
        end
        send_pkt(8'hFE, {8'h00, 32'($urandom())}, {32'($urandom()), 32'($urandom())});
        repeat (50) @(negedge clk);
        exp_stall = (3 < MAXC) ? 3 : MAXC;
        n_cmp++;
        if (cmd_q.size() !== exp_stall) begin n_mis++; $display("FAIL stall_cmd_count: observed %0d required %0d", cmd_q.size(), exp_stall); end
        n_cmp++;
        if (io_cmd_v_o !== 1'b0) begin n_mis++; $display("FAIL stall_cmd_v: observed %0h", io_cmd_v_o); end
        n_cmp++;
        if (nbf_q.size() !== 0) begin n_mis++; $display("FAIL fence_early_nbf: observed %0d", nbf_q.size()); end
        release_cycle = cycle + 200;
        hold_wr = 1'b0;
        wait_q(3, 1, 2000);
        n_cmp++;
        if (cmd_q.size() !== 3) begin n_mis++; $display("FAIL fence_cmd_count: observed %0d", cmd_q.size()); end
        for (int i = 0; i < 3; i++)
            if (cmd_q.size() > i) begin
                n_cmp++;
                if (cmd_q[i] !== exp_cmd(8'h03, wa[i], wd[i])) begin n_mis++; $display("FAIL fence_wr_cmd %0d: observed %0h", i, cmd_q[i]); end
            end
        n_cmp++;
        if (nbf_q.size() !== 1) begin n_mis++; $display("FAIL fence_nbf_count: observed %0d", nbf_q.size()); end
        if (nbf_q.size() > 0) begin
            n_cmp++;
            if (nbf_q[0] !== exp_nbf(8'hFE, 40'h0, 64'h0)) begin n_mis++; $display("FAIL fence_nbf: observed %0h", nbf_q[0]); end
            n_cmp++;
            if (nbf_acks_q[0] - base_acks !== 3) begin n_mis++; $display("FAIL fence_after_acks: observed %0d", nbf_acks_q[0] - base_acks); end
        end

        clear_q();
        resp_delay = 20;
        rd_data = 64'hDEADBEEF;
        a = 40'h00_8000_0008;
        d = {32'($urandom()), 32'($urandom())};
        send_pkt(8'h13, a, d);
        wait_q(1, 1, 600);
        n_cmp++;
        if (cmd_q.size() !== 1) begin n_mis++; $display("FAIL rd_cmd_count: observed %0d", cmd_q.size()); end
        if (cmd_q.size() > 0) begin
            n_cmp++;
            if (cmd_q[0] !== exp_cmd(8'h13, a, d)) begin n_mis++; $display("FAIL rd_cmd: observed %0h", cmd_q[0]); end
        end
        n_cmp++;
        if (nbf_q.size() > 0) begin
            if (nbf_q[0] !== {rd_data, a, 8'h13}) begin n_mis++; $display("FAIL rd_nbf: observed %0h", nbf_q[0]); end
        end else if (nbf_q.size() !== 1) begin
            n_mis++; $display("FAIL rd_nbf_count: observed %0d", nbf_q.size());
        end

        clear_q();
        ops[0] = 8'h55;
        ops[3] = 8'hFF;
        for (int i = 1; i < 3; i++) begin
            do op = 8'($urandom_range(0, 255));
            while (op == 8'h03 || op == 8'h13 || op == 8'hFE || op == 8'hFF);
            ops[i] = op;
        end
        for (int i = 0; i < 4; i++) begin
            a = {8'h00, 32'($urandom())};
            d = {32'($urandom()), 32'($urandom())};
            nbf_q.delete();
            send_pkt(ops[i], a, d);
            wait_q(0, 1, 200);
            n_cmp++;
            if (nbf_q.size() > 0) begin
                if (nbf_q[0] !== exp_nbf(ops[i], a, d)) begin n_mis++; $display("FAIL op_nbf %02h: observed %0h", ops[i], nbf_q[0]); end
            end else if (nbf_q.size() !== 1) begin
                n_mis++; $display("FAIL op_nbf_count %02h: observed %0d", ops[i], nbf_q.size());
            end
        end
        n_cmp++;
        if (cmd_q.size() !== 0) begin n_mis++; $display("FAIL op_no_cmd: observed %0d", cmd_q.size()); end

        clear_q();
        send_bits(8'hA5, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        wait_q(0, 1, 200);
        n_cmp++;
        if (nbf_q.size() > 0) begin
            if (nbf_q[0] !== err_nbf(64'h1)) begin n_mis++; $display("FAIL framing_nbf: observed %0h", nbf_q[0]); end
        end else if (nbf_q.size() !== 1) begin
            n_mis++; $display("FAIL framing_nbf_count: observed %0d", nbf_q.size());
        end

        clear_q();
        nbf_ready_and_i = 1'b0;
        a = {8'h00, 32'($urandom())};
        d = {32'($urandom()), 32'($urandom())};
        send_pkt(8'hFF, a, d);
        send_bits(8'h55, 1'b1);
        for (int i = 1; i < 20; i++) send_bits(8'($urandom()), 1'b1);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (nbf_q.size() !== 0) begin n_mis++; $display("FAIL overrun_held: observed %0d", nbf_q.size()); end
        nbf_ready_and_i = 1'b1;
        wait_q(0, 3, 300);
        n_cmp++;
        if (nbf_q.size() !== 3) begin n_mis++; $display("FAIL overrun_nbf_count: observed %0d", nbf_q.size()); end
        if (nbf_q.size() > 2) begin
            n_cmp++;
            if (nbf_q[0] !== exp_nbf(8'hFF, a, d)) begin n_mis++; $display("FAIL overrun_finish: observed %0h", nbf_q[0]); end
            n_cmp++;
            if (nbf_q[1] !== err_nbf(64'h2)) begin n_mis++; $display("FAIL overrun_err: observed %0h", nbf_q[1]); end
            n_cmp++;
            if (nbf_q[2] !== exp_nbf(8'h55, 40'h0, 64'h0)) begin n_mis++; $display("FAIL overrun_pkt: observed %0h", nbf_q[2]); end
        end

        a = {8'h00, 32'($urandom())};
        d = {32'($urandom()), 32'($urandom())};
        for (int i = 0; i < 5; i++) send_bits(8'($urandom()), 1'b1);
        reset_n_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (io_cmd_v_o !== 1'b0) begin n_mis++; $display("FAIL midreset_cmd_v: observed %0h", io_cmd_v_o); end
        n_cmp++;
        if (nbf_v_o !== 1'b0) begin n_mis++; $display("FAIL midreset_nbf_v: observed %0h", nbf_v_o); end
        @(negedge clk);
        reset_n_i = 1'b1;
        repeat (5) @(negedge clk);
        clear_q();
        send_pkt(8'h03, a, d);
        wait_q(1, 0, 400);
        repeat (100) @(negedge clk);
        n_cmp++;
        if (cmd_q.size() !== 1) begin n_mis++; $display("FAIL post_reset_cmd_count: observed %0d", cmd_q.size()); end
        if (cmd_q.size() > 0) begin
            n_cmp++;
            if (cmd_q[0] !== exp_cmd(8'h03, a, d)) begin n_mis++; $display("FAIL post_reset_cmd: observed %0h", cmd_q[0]); end
        end
        n_cmp++;
        if (nbf_q.size() !== 0) begin n_mis++; $display("FAIL post_reset_no_nbf: observed %0d", nbf_q.size()); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
